rv_mul_pipe: RTL

//  Parametrised, fully handshaked pipelined integer multiplier for the RV32IM/RV64M execute stage.

---
 rtl/rv_mul_pkg.sv | 31 +++
 rtl/rv_mul_half.sv | 16 +
 rtl/rv_mul_pipe.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/rv_mul_pkg.sv
// rv_mul_pkg: shared types and helpers for the pipelined RV32M/RV64M multiplier.
// Optional feature macro used by the top level: RV_MUL_FLUSH_EN (adds a flush input).
package rv_mul_pkg;

  // funct3[1:0] encoding of the multiply family
  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } rv_mul_op_e;

  // Per-stage control word. The tag and the width-dependent data registers
  // ride alongside it in each stage, sized by the module parameters.
  typedef struct packed {
    logic       valid;
    rv_mul_op_e op;
    logic       neg;
  } rv_mul_ctl_t;

  // True when the op returns the upper half of the 2*XLEN product.
  function automatic logic sel_high(input rv_mul_op_e op);
    logic hi;
    case (op)
      MUL:     hi = 1'b0;
      default: hi = 1'b1;
    endcase
    return hi;
  endfunction

endpackage

// File: rtl/rv_mul_half.sv
// rv_mul_half: unsigned HW x HW -> 2*HW combinational multiplier used for the
// four partial products of the pipelined multiplier.
module rv_mul_half #(
  parameter int HW = 16
) (
  input  logic [HW-1:0]   a_i,
  input  logic [HW-1:0]   b_i,
  output logic [2*HW-1:0] p_o
);

  // Zero-extend both operands so the product is evaluated at full result width.
  always_comb begin
    p_o = {{HW{1'b0}}, a_i} * {{HW{1'b0}}, b_i};
  end

endmodule

// File: rtl/rv_mul_pipe.sv
// rv_mul_pipe: three-stage valid/ready integer multiplier for MUL/MULH/MULHSU/MULHU.
//   S1: sign/magnitude operands, S2: four half-width partial products,
//   S3: summed, sign-corrected, half-selected result (drives out_*).
// Define RV_MUL_FLUSH_EN to add a flush input that empties all stages.
module rv_mul_pipe
  import rv_mul_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
`ifdef RV_MUL_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int HALF = XLEN / 2;
  localparam int PW   = 2 * XLEN;

  logic flush_s;

`ifdef RV_MUL_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  // Stage registers
  rv_mul_ctl_t      s1_ctl_q, s1_ctl_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic [XLEN-1:0]  s1_ma_q,  s1_ma_d;
  logic [XLEN-1:0]  s1_mb_q,  s1_mb_d;

  rv_mul_ctl_t      s2_ctl_q, s2_ctl_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic [XLEN-1:0]  s2_ll_q,  s2_ll_d;
  logic [XLEN-1:0]  s2_lh_q,  s2_lh_d;
  logic [XLEN-1:0]  s2_hl_q,  s2_hl_d;
  logic [XLEN-1:0]  s2_hh_q,  s2_hh_d;

  logic             s3_valid_q, s3_valid_d;
  logic [TAG_W-1:0] s3_tag_q,   s3_tag_d;
  logic [XLEN-1:0]  s3_res_q,   s3_res_d;

  // Combinational helpers
  logic             s1_load_s, s2_load_s, s3_load_s, accept_s;
  rv_mul_op_e       op_in_s;
  logic             neg_a_s, neg_b_s;
  logic [XLEN-1:0]  mag_a_s, mag_b_s;
  logic [XLEN-1:0]  pp_ll_s, pp_lh_s, pp_hl_s, pp_hh_s;
  logic [PW-1:0]    prod_s, signed_s;
  logic [XLEN-1:0]  res_s;

  // Load chain: a stage advances when empty or when its successor advances,
  // so bubbles collapse even while S3 is stalled.
  always_comb begin
    s3_load_s = ~s3_valid_q | out_ready;
    s2_load_s = ~s2_ctl_q.valid | s3_load_s;
    s1_load_s = ~s1_ctl_q.valid | s2_load_s;
    in_ready  = s1_load_s & ~flush_s;
    accept_s  = in_valid & in_ready;
  end

  // Operand sign detection and magnitude conversion (-2^(XLEN-1) maps to itself as unsigned).
  always_comb begin
    op_in_s = rv_mul_op_e'(in_op);
    neg_a_s = in_a[XLEN-1] & ((op_in_s == MULH) | (op_in_s == MULHSU));
    neg_b_s = in_b[XLEN-1] & (op_in_s == MULH);
    if (neg_a_s) begin
      mag_a_s = {XLEN{1'b0}} - in_a;
    end else begin
      mag_a_s = in_a;
    end
    if (neg_b_s) begin
      mag_b_s = {XLEN{1'b0}} - in_b;
    end else begin
      mag_b_s = in_b;
    end
  end

  rv_mul_half #(.HW(HALF)) u_pp_ll (.a_i(s1_ma_q[HALF-1:0]),    .b_i(s1_mb_q[HALF-1:0]),    .p_o(pp_ll_s));
  rv_mul_half #(.HW(HALF)) u_pp_lh (.a_i(s1_ma_q[HALF-1:0]),    .b_i(s1_mb_q[XLEN-1:HALF]), .p_o(pp_lh_s));
  rv_mul_half #(.HW(HALF)) u_pp_hl (.a_i(s1_ma_q[XLEN-1:HALF]), .b_i(s1_mb_q[HALF-1:0]),    .p_o(pp_hl_s));
  rv_mul_half #(.HW(HALF)) u_pp_hh (.a_i(s1_ma_q[XLEN-1:HALF]), .b_i(s1_mb_q[XLEN-1:HALF]), .p_o(pp_hh_s));

  // Partial-product summation, sign fix-up and half selection feeding S3.
  always_comb begin
    prod_s = {{XLEN{1'b0}}, s2_ll_q}
           + {{HALF{1'b0}}, s2_lh_q, {HALF{1'b0}}}
           + {{HALF{1'b0}}, s2_hl_q, {HALF{1'b0}}}
           + {s2_hh_q, {XLEN{1'b0}}};
    if (s2_ctl_q.neg) begin
      signed_s = {PW{1'b0}} - prod_s;
    end else begin
      signed_s = prod_s;
    end
    if (sel_high(s2_ctl_q.op)) begin
      res_s = signed_s[PW-1:XLEN];
    end else begin
      res_s = signed_s[XLEN-1:0];
    end
  end

  // Next-state for all stages; data only moves with a valid op, flush clears valids only.
  always_comb begin
    s1_ctl_d   = s1_ctl_q;
    s1_tag_d   = s1_tag_q;
    s1_ma_d    = s1_ma_q;
    s1_mb_d    = s1_mb_q;
    s2_ctl_d   = s2_ctl_q;
    s2_tag_d   = s2_tag_q;
    s2_ll_d    = s2_ll_q;
    s2_lh_d    = s2_lh_q;
    s2_hl_d    = s2_hl_q;
    s2_hh_d    = s2_hh_q;
    s3_valid_d = s3_valid_q;
    s3_tag_d   = s3_tag_q;
    s3_res_d   = s3_res_q;

    if (s1_load_s) begin
      s1_ctl_d.valid = accept_s;
      if (accept_s) begin
        s1_ctl_d.op  = op_in_s;
        s1_ctl_d.neg = neg_a_s ^ neg_b_s;
        s1_tag_d     = in_tag;
        s1_ma_d      = mag_a_s;
        s1_mb_d      = mag_b_s;
      end else begin
        s1_tag_d     = s1_tag_q;
      end
    end else begin
      s1_ctl_d = s1_ctl_q;
    end

    if (s2_load_s) begin
      s2_ctl_d.valid = s1_ctl_q.valid;
      if (s1_ctl_q.valid & ~flush_s) begin
        s2_ctl_d = s1_ctl_q;
        s2_tag_d = s1_tag_q;
        s2_ll_d  = pp_ll_s;
        s2_lh_d  = pp_lh_s;
        s2_hl_d  = pp_hl_s;
        s2_hh_d  = pp_hh_s;
      end else begin
        s2_tag_d = s2_tag_q;
      end
    end else begin
      s2_ctl_d = s2_ctl_q;
    end

    if (s3_load_s) begin
      s3_valid_d = s2_ctl_q.valid;
      if (s2_ctl_q.valid & ~flush_s) begin
        s3_tag_d = s2_tag_q;
        s3_res_d = res_s;
      end else begin
        s3_tag_d = s3_tag_q;
      end
    end else begin
      s3_valid_d = s3_valid_q;
    end

    if (flush_s) begin
      s1_ctl_d.valid = 1'b0;
      s2_ctl_d.valid = 1'b0;
      s3_valid_d     = 1'b0;
    end else begin
      s3_valid_d     = s3_valid_d;
    end
  end

  // Pipeline state registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_ctl_q   <= '0;
      s1_tag_q   <= {TAG_W{1'b0}};
      s1_ma_q    <= {XLEN{1'b0}};
      s1_mb_q    <= {XLEN{1'b0}};
      s2_ctl_q   <= '0;
      s2_tag_q   <= {TAG_W{1'b0}};
      s2_ll_q    <= {XLEN{1'b0}};
      s2_lh_q    <= {XLEN{1'b0}};
      s2_hl_q    <= {XLEN{1'b0}};
      s2_hh_q    <= {XLEN{1'b0}};
      s3_valid_q <= 1'b0;
      s3_tag_q   <= {TAG_W{1'b0}};
      s3_res_q   <= {XLEN{1'b0}};
    end else begin
      s1_ctl_q   <= s1_ctl_d;
      s1_tag_q   <= s1_tag_d;
      s1_ma_q    <= s1_ma_d;
      s1_mb_q    <= s1_mb_d;
      s2_ctl_q   <= s2_ctl_d;
      s2_tag_q   <= s2_tag_d;
      s2_ll_q    <= s2_ll_d;
      s2_lh_q    <= s2_lh_d;
      s2_hl_q    <= s2_hl_d;
      s2_hh_q    <= s2_hh_d;
      s3_valid_q <= s3_valid_d;
      s3_tag_q   <= s3_tag_d;
      s3_res_q   <= s3_res_d;
    end
  end

  assign out_valid  = s3_valid_q;
  assign out_result = s3_res_q;
  assign out_tag    = s3_tag_q;

endmodule
